// File: rtl/pid_core.sv
// pid_core: sequential PID controller producing an unsigned DAC code.
// Each accepted start computes e = setpoint - meas and de = e - e_prev,
// forms kp*e, ki*e and kd*de with a shared GAIN_W-cycle shift-add multiplier,
// updates a saturating integrator and clips the sum into 0 .. 2^DATA_W-1.
// Fixed latency: done rises 3*GAIN_W+3 edges after the edge that accepts start.
// Optional feature macro: PID_ANTIWINDUP_EN (integrator holds while the
// previous result was clipped in the direction the error is still pushing).
// Parameter legality: ACC_W >= DATA_W+GAIN_W+2.

module pid_core #(
  parameter int DATA_W = 8,
  parameter int GAIN_W = 4,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              start,
  input  logic [DATA_W-1:0] setpoint,
  input  logic [DATA_W-1:0] meas,
  input  logic [GAIN_W-1:0] kp,
  input  logic [GAIN_W-1:0] ki,
  input  logic [GAIN_W-1:0] kd,
  input  logic              clr_i,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] out,
  output logic              sat
);

  // error, error delta, product, control sum and step counter widths
  localparam int EW = DATA_W + 1;
  localparam int DW = DATA_W + 2;
  localparam int PW = DATA_W + GAIN_W + 2;
  localparam int UW = ACC_W + 2;
  localparam int CW = (GAIN_W > 1) ? $clog2(GAIN_W) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ERR   = 3'd1,
    MUL_P = 3'd2,
    MUL_I = 3'd3,
    MUL_D = 3'd4,
    SUM   = 3'd5,
    DONE  = 3'd6
  } state_t;

  // Saturate an ACC_W+1 bit sum into the ACC_W integrator range instead of wrapping.
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] v);
    logic signed [ACC_W-1:0] res;
    if (v[ACC_W] != v[ACC_W-1]) begin
      if (v[ACC_W]) begin
        res = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        res = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      res = v[ACC_W-1:0];
    end
    return res;
  endfunction

  state_t                   r_state;
  state_t                   w_next_state;

  logic                     r_busy;
  logic                     r_done;
  logic [DATA_W-1:0]        r_out;
  logic                     r_sat;

  logic signed [EW-1:0]     r_e;
  logic signed [EW-1:0]     r_e_prev;
  logic signed [DW-1:0]     r_de;
  logic signed [ACC_W-1:0]  r_i_acc;

  // shift-add multiplier: multiplicand shifts left, gain shifts right
  logic signed [PW-1:0]     r_mcand;
  logic [GAIN_W-1:0]        r_mult;
  logic signed [PW-1:0]     r_prod;
  logic [CW-1:0]            r_cnt;

  logic signed [PW-1:0]     r_p_prod;
  logic signed [PW-1:0]     r_i_prod;
  logic signed [PW-1:0]     r_d_prod;
  logic signed [UW-1:0]     r_u;

  logic signed [EW-1:0]     w_e;
  logic signed [DW-1:0]     w_de;
  logic                     w_last_step;
  logic signed [PW-1:0]     w_prod_next;
  logic signed [ACC_W:0]    w_isum;
  logic                     w_hold;
  logic signed [ACC_W-1:0]  w_i_new;
  logic signed [UW-1:0]     w_u;
  logic [DATA_W-1:0]        w_clip_out;
  logic                     w_clip_sat;

  assign busy = r_busy;
  assign done = r_done;
  assign out  = r_out;
  assign sat  = r_sat;

  // State register; reset wins over any pending start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: each multiply phase runs GAIN_W steps, all others one cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start && en) begin
          w_next_state = ERR;
        end else begin
          w_next_state = IDLE;
        end
      end
      ERR: w_next_state = MUL_P;
      MUL_P: begin
        if (w_last_step) begin
          w_next_state = MUL_I;
        end else begin
          w_next_state = MUL_P;
        end
      end
      MUL_I: begin
        if (w_last_step) begin
          w_next_state = MUL_D;
        end else begin
          w_next_state = MUL_I;
        end
      end
      MUL_D: begin
        if (w_last_step) begin
          w_next_state = SUM;
        end else begin
          w_next_state = MUL_D;
        end
      end
      SUM:     w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Arithmetic: error terms, one multiplier step, integrator update and output clip.
  always_comb begin
    w_e         = $signed({1'b0, setpoint}) - $signed({1'b0, meas});
    w_de        = DW'(w_e) - DW'(r_e_prev);
    w_last_step = (r_cnt == CW'(GAIN_W - 1));
    if (r_mult[0]) begin
      w_prod_next = r_prod + r_mcand;
    end else begin
      w_prod_next = r_prod;
    end
    w_isum = (ACC_W+1)'(r_i_acc) + (ACC_W+1)'(r_i_prod);
`ifdef PID_ANTIWINDUP_EN
    // Freeze the integrator while the last output was pinned at a rail
    // and the error keeps pushing further into that rail.
    w_hold = r_sat &&
             (((r_out == {DATA_W{1'b1}}) && !r_e[EW-1] && (r_e != {EW{1'b0}})) ||
              ((r_out == {DATA_W{1'b0}}) && r_e[EW-1]));
`else
    w_hold = 1'b0;
`endif
    if (w_hold) begin
      w_i_new = r_i_acc;
    end else begin
      w_i_new = sat_acc(w_isum);
    end
    w_u = UW'(r_p_prod) + UW'(w_i_new) + UW'(r_d_prod);
    if (r_u[UW-1]) begin
      w_clip_out = {DATA_W{1'b0}};
      w_clip_sat = 1'b1;
    end else if (|r_u[UW-2:DATA_W]) begin
      w_clip_out = {DATA_W{1'b1}};
      w_clip_sat = 1'b1;
    end else begin
      w_clip_out = r_u[DATA_W-1:0];
      w_clip_sat = 1'b0;
    end
  end

  // Datapath and registered outputs, sequenced by the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_out    <= {DATA_W{1'b0}};
      r_sat    <= 1'b0;
      r_e      <= {EW{1'b0}};
      r_e_prev <= {EW{1'b0}};
      r_de     <= {DW{1'b0}};
      r_i_acc  <= {ACC_W{1'b0}};
      r_mcand  <= {PW{1'b0}};
      r_mult   <= {GAIN_W{1'b0}};
      r_prod   <= {PW{1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_p_prod <= {PW{1'b0}};
      r_i_prod <= {PW{1'b0}};
      r_d_prod <= {PW{1'b0}};
      r_u      <= {UW{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // clear lands on the same edge that may accept start, so ERR sees e_prev = 0
          if (clr_i) begin
            r_i_acc  <= {ACC_W{1'b0}};
            r_e_prev <= {EW{1'b0}};
          end
          if (start && en) begin
            r_busy <= 1'b1;
          end
        end
        ERR: begin
          r_e     <= w_e;
          r_de    <= w_de;
          r_mcand <= PW'(w_e);
          r_mult  <= kp;
          r_prod  <= {PW{1'b0}};
          r_cnt   <= {CW{1'b0}};
        end
        MUL_P: begin
          if (w_last_step) begin
            r_p_prod <= w_prod_next;
            r_mcand  <= PW'(r_e);
            r_mult   <= ki;
            r_prod   <= {PW{1'b0}};
            r_cnt    <= {CW{1'b0}};
          end else begin
            r_prod  <= w_prod_next;
            r_mcand <= r_mcand <<< 1;
            r_mult  <= r_mult >> 1;
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        MUL_I: begin
          if (w_last_step) begin
            r_i_prod <= w_prod_next;
            r_mcand  <= PW'(r_de);
            r_mult   <= kd;
            r_prod   <= {PW{1'b0}};
            r_cnt    <= {CW{1'b0}};
          end else begin
            r_prod  <= w_prod_next;
            r_mcand <= r_mcand <<< 1;
            r_mult  <= r_mult >> 1;
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        MUL_D: begin
          if (w_last_step) begin
            r_d_prod <= w_prod_next;
            r_prod   <= {PW{1'b0}};
            r_cnt    <= {CW{1'b0}};
          end else begin
            r_prod  <= w_prod_next;
            r_mcand <= r_mcand <<< 1;
            r_mult  <= r_mult >> 1;
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        SUM: begin
          r_i_acc  <= w_i_new;
          r_u      <= w_u;
          r_e_prev <= r_e;
        end
        DONE: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_out  <= w_clip_out;
          r_sat  <= w_clip_sat;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pid_core.sv
// tb_pid_core: scoreboard bench for pid_core. A behavioural integer model
// predicts out/sat for each accepted start and queues it; a monitor pops and
// compares whenever done is seen. Scenario tasks add latency, reset and
// protocol checks inline. Build with +define+PID_ANTIWINDUP_EN to exercise
// the anti-windup variant.

module tb_pid_core;

  localparam int DATA_W  = 8;
  localparam int GAIN_W  = 4;
  localparam int ACC_W   = 16;
  localparam int LAT     = 3 * GAIN_W + 3;
  localparam int OUT_MAX = 255;
  localparam int ACC_MAX = 32767;
  localparam int ACC_MIN = -32768;

  logic              clk      = 1'b0;
  logic              reset    = 1'b1;
  logic              en       = 1'b0;
  logic              start    = 1'b0;
  logic [DATA_W-1:0] setpoint = 8'd0;
  logic [DATA_W-1:0] meas     = 8'd0;
  logic [GAIN_W-1:0] kp       = 4'd0;
  logic [GAIN_W-1:0] ki       = 4'd0;
  logic [GAIN_W-1:0] kd       = 4'd0;
  logic              clr_i    = 1'b0;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] out;
  logic              sat;

  typedef struct packed {
    logic [DATA_W-1:0] out;
    logic              sat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;
  int   n_total = 0;
  int   n_bad   = 0;

  // reference model state
  int   m_iacc  = 0;
  int   m_eprev = 0;
  int   m_out   = 0;
  bit   m_sat   = 1'b0;

  pid_core #(.DATA_W(DATA_W), .GAIN_W(GAIN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .en(en), .start(start),
    .setpoint(setpoint), .meas(meas), .kp(kp), .ki(ki), .kd(kd),
    .clr_i(clr_i), .busy(busy), .done(done), .out(out), .sat(sat)
  );

  always #5 clk = ~clk;

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard monitor: every done pulse must match the oldest prediction
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_total++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done: got out=%0d sat=%0b, required no done", out, sat);
      end else begin
        mon_x = sb.pop_front();
        if ({out, sat} !== {mon_x.out, mon_x.sat}) begin
          n_bad++;
          $display("FAIL result: got out=%0d sat=%0b, required out=%0d sat=%0b",
                   out, sat, mon_x.out, mon_x.sat);
        end
      end
    end
  end

  task automatic model_reset();
    sb.delete();
    m_iacc  = 0;
    m_eprev = 0;
    m_out   = 0;
    m_sat   = 1'b0;
  endtask

  task automatic model_push(input int sp, input int ms, input int g_p, input int g_i, input int g_d);
    int   e, de, u;
    bit   hold;
    exp_t x;
    e    = sp - ms;
    de   = e - m_eprev;
    hold = 1'b0;
`ifdef PID_ANTIWINDUP_EN
    hold = m_sat && ((m_out == OUT_MAX && e > 0) || (m_out == 0 && e < 0));
`endif
    if (!hold) begin
      m_iacc = m_iacc + g_i * e;
      if (m_iacc > ACC_MAX) m_iacc = ACC_MAX;
      if (m_iacc < ACC_MIN) m_iacc = ACC_MIN;
    end
    u = g_p * e + m_iacc + g_d * de;
    if (u < 0) begin
      m_out = 0;
      m_sat = 1'b1;
    end else if (u > OUT_MAX) begin
      m_out = OUT_MAX;
      m_sat = 1'b1;
    end else begin
      m_out = u;
      m_sat = 1'b0;
    end
    m_eprev = e;
    x.out   = DATA_W'(m_out);
    x.sat   = m_sat;
    sb.push_back(x);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One control update: start with en, drop en right after acceptance, wait for done.
  // scramble: change setpoint/meas/kp after they were sampled; clr_mid: clr_i pulse while busy.
  task automatic do_op(input int sp, input int ms, input int g_p, input int g_i, input int g_d,
                       input bit clr, input bit scramble, input bit clr_mid);
    int lat;
    setpoint = DATA_W'(sp);
    meas     = DATA_W'(ms);
    kp       = GAIN_W'(g_p);
    ki       = GAIN_W'(g_i);
    kd       = GAIN_W'(g_d);
    clr_i    = clr;
    start    = 1'b1;
    en       = 1'b1;
    if (clr) begin
      m_iacc  = 0;
      m_eprev = 0;
    end
    model_push(sp, ms, g_p, g_i, g_d);
    @(posedge clk); #1;
    start = 1'b0;
    en    = 1'b0;
    clr_i = 1'b0;
    lat   = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (scramble && n == 2) begin
        setpoint = DATA_W'($urandom);
        meas     = DATA_W'($urandom);
        kp       = GAIN_W'($urandom);
      end
      if (clr_mid) clr_i = (n == 3);
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    clr_i = 1'b0;
    n_total++;
    if (lat !== LAT) begin
      n_bad++;
      $display("FAIL latency: got %0d edges, required %0d", lat, LAT);
    end
    n_total++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_at_done: got %0b, required 0", busy);
    end
  endtask

  task automatic test_reset();
    start = 1'b1;
    en    = 1'b1;
    clr_i = 1'b1;
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    n_total++;
    if ({busy, done, out, sat} !== {1'b0, 1'b0, 8'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: got busy=%0b done=%0b out=%0d sat=%0b, required all 0",
               busy, done, out, sat);
    end
    start = 1'b0;
    en    = 1'b0;
    clr_i = 1'b0;
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    n_total++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_proportional();
    pulse_reset();
    do_op(100, 90, 2, 0, 0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if ({out, sat} !== {8'd20, 1'b0}) begin
      n_bad++;
      $display("FAIL prop_direct: got out=%0d sat=%0b, required out=20 sat=0", out, sat);
    end
  endtask

  task automatic test_integral();
    pulse_reset();
    for (int k = 0; k < 3; k++) do_op(15, 10, 0, 1, 0, 1'b0, 1'b0, 1'b0);
    clr_i = 1'b1;
    @(posedge clk); #1;
    clr_i   = 1'b0;
    m_iacc  = 0;
    m_eprev = 0;
    do_op(15, 10, 0, 1, 0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (out !== 8'd5) begin
      n_bad++;
      $display("FAIL integ_after_clr: got out=%0d, required 5", out);
    end
    // clear together with start: clear first, then accumulate once
    do_op(15, 10, 0, 1, 0, 1'b1, 1'b0, 1'b0);
    // clear while busy must not touch the integrator
    do_op(15, 10, 0, 1, 0, 1'b0, 1'b0, 1'b1);
    n_total++;
    if (out !== 8'd10) begin
      n_bad++;
      $display("FAIL clr_while_busy: got out=%0d, required 10", out);
    end
  endtask

  task automatic test_derivative();
    pulse_reset();
    do_op(14, 10, 0, 0, 3, 1'b0, 1'b0, 1'b0);
    do_op(14, 10, 0, 0, 3, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (out !== 8'd0) begin
      n_bad++;
      $display("FAIL deriv_zero: got out=%0d, required 0", out);
    end
  endtask

  task automatic test_saturation();
    pulse_reset();
    do_op(0, 200, 15, 0, 0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if ({out, sat} !== {8'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL clip_low: got out=%0d sat=%0b, required out=0 sat=1", out, sat);
    end
    do_op(200, 0, 15, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int   dones;
    logic [DATA_W-1:0] held;
    pulse_reset();
    setpoint = 8'd30;
    meas     = 8'd20;
    kp       = 4'd1;
    ki       = 4'd0;
    kd       = 4'd0;
    start    = 1'b1;
    en       = 1'b1;
    model_push(30, 20, 1, 0, 0);
    dones = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 11) start = 1'b0;
      if (done === 1'b1) dones++;
    end
    en = 1'b0;
    n_total++;
    if (dones !== 1) begin
      n_bad++;
      $display("FAIL start_while_busy: got %0d done pulses, required 1", dones);
    end
    held = out;
    n_total++;
    if (held !== 8'd10) begin
      n_bad++;
      $display("FAIL b2b_value: got out=%0d, required 10", held);
    end
    setpoint = 8'd0;
    meas     = 8'd99;
    repeat (5) begin
      @(posedge clk); #1;
    end
    n_total++;
    if ({out, sat, busy} !== {8'd10, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL hold_output: got out=%0d sat=%0b busy=%0b, required out=10 sat=0 busy=0",
               out, sat, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit saw;
    pulse_reset();
    do_op(200, 0, 15, 0, 0, 1'b0, 1'b0, 1'b0);
    setpoint = 8'd50;
    meas     = 8'd10;
    kp       = 4'd3;
    start    = 1'b1;
    en       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    en    = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    n_total++;
    if ({busy, done, out, sat} !== {1'b0, 1'b0, 8'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid: got busy=%0b done=%0b out=%0d sat=%0b, required all 0",
               busy, done, out, sat);
    end
    saw = 1'b0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw = 1'b1;
    end
    n_total++;
    if (saw !== 1'b0) begin
      n_bad++;
      $display("FAIL done_after_abort: got done pulse, required none");
    end
    do_op(5, 0, 0, 1, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      do_op($urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(15, 0),
            $urandom_range(15, 0), $urandom_range(15, 0), 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_antiwindup();
    pulse_reset();
    for (int k = 0; k < 4; k++) do_op(150, 50, 15, 1, 0, 1'b0, 1'b0, 1'b0);
    do_op(50, 51, 15, 1, 0, 1'b0, 1'b0, 1'b0);
    n_total++;
`ifdef PID_ANTIWINDUP_EN
    if ({out, sat} !== {8'd84, 1'b0}) begin
      n_bad++;
      $display("FAIL antiwindup: got out=%0d sat=%0b, required out=84 sat=0", out, sat);
    end
`else
    if ({out, sat} !== {8'd255, 1'b1}) begin
      n_bad++;
      $display("FAIL windup: got out=%0d sat=%0b, required out=255 sat=1", out, sat);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_proportional();
    test_integral();
    test_derivative();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_antiwindup();
    repeat (3) begin
      @(posedge clk); #1;
    end
    n_total++;
    if (sb.size() !== 0) begin
      n_bad++;
      $display("FAIL missing_results: got %0d undelivered predictions, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
